player_move_arbiter: RTL and testbench
======================================

Name: player_move_arbiter

Overview:
Schedules player "move" requests from the four debounced buttons into the race core, one or more grants per LED frame.
- Detects press edges and queues them in per-player saturating counters.
- On each frame boundary (update_frame rising edge from the WS2812B driver), grants queued moves in round-robin order.
- Sits between the four button_debouncer instances and LEDs_racer_core, so simultaneous presses are served fairly and never lost silently.

Parameters:
MAX_PENDING, 3, saturation value of each per-player pending counter (≥1)
GRANTS_PER_FRAME, 1, maximum moves granted per frame boundary (1..4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
update_frame  in  1  frame-boundary level from WS2812B driver; rising edge starts a grant burst
enable  in  1  1 = race screen active; 0 = flush and ignore presses
btn_green  in  1  debounced level, player 0
btn_red  in  1  debounced level, player 1
btn_blue  in  1  debounced level, player 2
btn_yellow  in  1  debounced level, player 3
move_green / move_red / move_blue / move_yellow  out  1 each  one-cycle grant pulse per player (mutually exclusive)
grant_valid  out  1  high in any cycle a move_* pulse is high
grant_id  out  2  index of granted player (0 green, 1 red, 2 blue, 3 yellow); 0 when grant_valid=0
drop_press  out  4  one-cycle pulse per player when a press is discarded because its counter is saturated
pending_any  out  1  registered OR of all pending counters being non-zero

Behaviour:
- Reset (sync, highest priority):
  - All outputs 0; pending counters 0; rr_ptr 0; grant counter 0; state IDLE.
  - Button history registers = 1, so a button held through reset does not produce a press.
  - update_frame history = 1, so a frame edge needs a preceding low sample.
- Press detect: press[i] = btn_i & ~btn_q[i]; btn_q updates every cycle, including while enable=0.
- Pending counter i (width $clog2(MAX_PENDING+1)), updated at the same edge the press is sampled:
  - press & no grant to i: +1 if < MAX_PENDING; otherwise hold and pulse drop_press[i] next cycle.
  - grant to i & no press: −1.
  - press & grant to i in the same cycle: hold, no drop, even when saturated.
- Frame edge: fe = update_frame & ~update_frame_q.
- FSM states IDLE, GRANT:
  - IDLE: if fe & enable & any pending → GRANT, grant counter cleared. Otherwise stay.
  - GRANT, each cycle:
    - Pick the first i with pending[i] ≠ 0, scanning from rr_ptr upward mod 4.
    - Register move_i = 1, grant_valid = 1, grant_id = i.
    - Decrement pending[i]; rr_ptr ← (i+1) mod 4; grant counter +1.
    - Return to IDLE when the grant counter reaches GRANTS_PER_FRAME or no further pending remains after this grant.
  - A fe occurring while in GRANT is ignored (not queued).
- Latency:
  - update_frame sampled high at edge E0 (low at E−1) → state GRANT at E0.
  - First move pulse is registered at E1 and held high for exactly one cycle.
  - Consecutive grants in one burst occur in back-to-back cycles.
- Only one move_* is high in any cycle; move_* and grant_valid are low in every other cycle.
- enable = 0:
  - Pending counters cleared to 0 at the next edge.
  - Presses ignored, no drop pulses, FSM forced to IDLE, any in-progress burst aborted.
  - rr_ptr retained.
- Reset asserted mid-burst: the next cycle shows reset values; no further pulses.
- pending_any is registered from post-update counters, so it lags the counter state by one cycle.

Decomposition:
- racer_pkg:
  - Player index constants PLAYER_GREEN=0, PLAYER_RED=1, PLAYER_BLUE=2, PLAYER_YELLOW=3.
  - NUM_PLAYERS=4.
  - Arbiter state enum {IDLE, GRANT}.
- Sub-module rr_priority_picker (combinational):
  - Inputs: 4-bit request vector and 2-bit rr_ptr.
  - Outputs: found flag and 2-bit winner index.
  - Reusable by future shared-resource arbiters.

Test Plan:
- Reset with btn_red held high, release reset, keep btn_red high 10 cycles → pending stays 0, no drop_press, no move pulse on the next frame edge.
- Single green press, then update_frame 0→1 at edge E0 → move_green high only in cycle E1..E2, grant_id=0, grant_valid=1, pending_any falls to 0.
- All four buttons pressed in the same cycle, GRANTS_PER_FRAME=1, four frame edges → grants in order green, red, blue, yellow (rr_ptr 0→1→2→3→0), one per frame.
- Four green presses, MAX_PENDING=3 → pending saturates at 3; fourth press yields drop_press=4'b0001 for one cycle; then exactly 3 green grants over 3 frames.
- GRANTS_PER_FRAME=4, red and yellow pending, one frame edge → move_red then move_yellow in consecutive cycles, then IDLE; a second frame edge arriving during the burst is ignored.
- Green pending=2, drop enable for one cycle, raise it, then frame edge → no grant.
- Green press coincident with its own grant while saturated → counter holds at MAX_PENDING, no drop_press.

Source files
------------

// File: rtl/racer_pkg.sv
// racer_pkg
// Shared definitions for the LED racer player logic.
//   NUM_PLAYERS     : number of player buttons / lanes
//   PLAYER_*        : player index constants (green, red, blue, yellow)
//   arb_state_t     : move arbiter FSM states
package racer_pkg;

    localparam int unsigned NUM_PLAYERS = 4;

    localparam logic [1:0] PLAYER_GREEN  = 2'd0;
    localparam logic [1:0] PLAYER_RED    = 2'd1;
    localparam logic [1:0] PLAYER_BLUE   = 2'd2;
    localparam logic [1:0] PLAYER_YELLOW = 2'd3;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker
// Combinational round-robin picker. It scans the request vector upward
// from rr_ptr, wrapping modulo NUM_PLAYERS, and returns the first set bit.
//   req    : in  request vector, one bit per player
//   rr_ptr : in  index where the scan starts
//   found  : out at least one request is set
//   winner : out index of the selected request (0 when found=0)
module rr_priority_picker
    import racer_pkg::*;
(
    input  logic [NUM_PLAYERS-1:0] req,
    input  logic [1:0]             rr_ptr,
    output logic                   found,
    output logic [1:0]             winner
);

    logic [1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/player_move_arbiter.sv
// player_move_arbiter
// Queues debounced button presses in per-player saturating counters and
// grants them as one-cycle move pulses in round-robin order, starting on
// each rising edge of update_frame.
//   clk, reset          : system clock, synchronous active-high reset
//   update_frame        : frame-boundary level; rising edge starts a grant burst
//   enable              : race screen active; 0 flushes counters, ignores presses
//   btn_green..yellow   : debounced button levels, players 0..3
//   move_green..yellow  : one-cycle grant pulse per player (mutually exclusive)
//   grant_valid         : high when any move_* pulse is high
//   grant_id            : index of the granted player, 0 when idle
//   drop_press          : per-player pulse when a press hit a saturated counter
//   pending_any         : registered "any counter non-zero" (one cycle lag)
module player_move_arbiter
    import racer_pkg::*;
#(
    parameter int unsigned MAX_PENDING      = 3,
    parameter int unsigned GRANTS_PER_FRAME = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       update_frame,
    input  logic       enable,
    input  logic       btn_green,
    input  logic       btn_red,
    input  logic       btn_blue,
    input  logic       btn_yellow,
    output logic       move_green,
    output logic       move_red,
    output logic       move_blue,
    output logic       move_yellow,
    output logic       grant_valid,
    output logic [1:0] grant_id,
    output logic [3:0] drop_press,
    output logic       pending_any
);

    localparam int unsigned    CW        = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0]  PEND_MAX  = CW'(MAX_PENDING);
    localparam logic [CW-1:0]  PEND_ONE  = CW'(1);
    localparam logic [2:0]     GCNT_LAST = 3'(GRANTS_PER_FRAME);

    logic [NUM_PLAYERS-1:0] btn;
    logic [NUM_PLAYERS-1:0] btn_q;
    logic [NUM_PLAYERS-1:0] press;
    logic                   frame_q;
    logic                   fe;

    logic [CW-1:0]          pending     [NUM_PLAYERS];
    logic [CW-1:0]          pending_nxt [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] req;
    logic [NUM_PLAYERS-1:0] req_nxt;
    logic [NUM_PLAYERS-1:0] drop_nxt;

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [1:0]             rr_ptr;
    logic [1:0]             rr_ptr_nxt;
    logic [2:0]             gcnt;
    logic [2:0]             gcnt_nxt;

    logic                   found;
    logic [1:0]             winner;
    logic [NUM_PLAYERS-1:0] grant;
    logic [NUM_PLAYERS-1:0] move_q;

    assign btn = {btn_yellow, btn_blue, btn_red, btn_green};
    assign press = btn & ~btn_q;
    assign fe    = update_frame & ~frame_q;

    assign move_green  = move_q[PLAYER_GREEN];
    assign move_red    = move_q[PLAYER_RED];
    assign move_blue   = move_q[PLAYER_BLUE];
    assign move_yellow = move_q[PLAYER_YELLOW];

    always_comb begin
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            req[i] = (pending[i] != '0);
        end
    end

    rr_priority_picker u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (found),
        .winner (winner)
    );

    // Grant for this cycle, derived from registered counters only so the
    // counter update and the FSM can both consume it without a loop.
    always_comb begin
        grant = '0;
        if (state == GRANT && enable && found) begin
            grant[winner] = 1'b1;
        end
    end

    // Counter update. A press coinciding with a grant to the same player
    // cancels out, so a saturated counter holds without dropping.
    always_comb begin
        drop_nxt = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            pending_nxt[i] = pending[i];
            if (!enable) begin
                pending_nxt[i] = '0;
            end else if (press[i] && !grant[i]) begin
                if (pending[i] < PEND_MAX) begin
                    pending_nxt[i] = pending[i] + PEND_ONE;
                end else begin
                    drop_nxt[i] = 1'b1;
                end
            end else if (grant[i] && !press[i]) begin
                pending_nxt[i] = pending[i] - PEND_ONE;
            end
            req_nxt[i] = (pending_nxt[i] != '0);
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        gcnt_nxt   = gcnt;
        case (state)
            IDLE: begin
                if (enable && fe && (|req)) begin
                    state_nxt = GRANT;
                    gcnt_nxt  = '0;
                end
            end
            GRANT: begin
                if (!enable || !found) begin
                    state_nxt = IDLE;
                end else begin
                    rr_ptr_nxt = winner + 2'd1;
                    gcnt_nxt   = gcnt + 3'd1;
                    if (gcnt_nxt == GCNT_LAST || !(|req_nxt)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q       <= '1;
            frame_q     <= 1'b1;
            pending     <= '{default: '0};
            state       <= IDLE;
            rr_ptr      <= '0;
            gcnt        <= '0;
            move_q      <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            drop_press  <= '0;
            pending_any <= 1'b0;
        end else begin
            btn_q       <= btn;
            frame_q     <= update_frame;
            pending     <= pending_nxt;
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            gcnt        <= gcnt_nxt;
            move_q      <= grant;
            grant_valid <= |grant;
            grant_id    <= (|grant) ? winner : 2'd0;
            drop_press  <= drop_nxt;
            pending_any <= |req;
        end
    end

endmodule

// File: tb/tb_player_move_arbiter.sv
// tb_player_move_arbiter
// Directed bench for player_move_arbiter. Two instances share all inputs:
// dut1 uses GRANTS_PER_FRAME=1, dut4 uses GRANTS_PER_FRAME=4; each scenario
// starts from reset and checks only the instance it targets.
module tb_player_move_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       update_frame;
    logic       enable;
    logic       btn_green, btn_red, btn_blue, btn_yellow;

    logic       m1_g, m1_r, m1_b, m1_y, gv1, pa1;
    logic [1:0] gid1;
    logic [3:0] drop1;
    logic       m4_g, m4_r, m4_b, m4_y, gv4, pa4;
    logic [1:0] gid4;
    logic [3:0] drop4;
    logic [3:0] mv1, mv4;

    int checks   = 0;
    int failures = 0;

    assign mv1 = {m1_y, m1_b, m1_r, m1_g};
    assign mv4 = {m4_y, m4_b, m4_r, m4_g};

    always #5 clk = ~clk;

    player_move_arbiter #(.MAX_PENDING(3), .GRANTS_PER_FRAME(1)) dut1 (
        .clk(clk), .reset(reset), .update_frame(update_frame), .enable(enable),
        .btn_green(btn_green), .btn_red(btn_red), .btn_blue(btn_blue), .btn_yellow(btn_yellow),
        .move_green(m1_g), .move_red(m1_r), .move_blue(m1_b), .move_yellow(m1_y),
        .grant_valid(gv1), .grant_id(gid1), .drop_press(drop1), .pending_any(pa1)
    );

    player_move_arbiter #(.MAX_PENDING(3), .GRANTS_PER_FRAME(4)) dut4 (
        .clk(clk), .reset(reset), .update_frame(update_frame), .enable(enable),
        .btn_green(btn_green), .btn_red(btn_red), .btn_blue(btn_blue), .btn_yellow(btn_yellow),
        .move_green(m4_g), .move_red(m4_r), .move_blue(m4_b), .move_yellow(m4_y),
        .grant_valid(gv4), .grant_id(gid4), .drop_press(drop4), .pending_any(pa4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns 1 ns after the next rising edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btns(input logic [3:0] v);
        {btn_yellow, btn_blue, btn_red, btn_green} = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        update_frame = 1'b0;
        enable = 1'b1;
        set_btns(4'b0000);
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic press(input logic [3:0] v);
        set_btns(v);
        step(1);
        set_btns(4'b0000);
        step(1);
    endtask

    // Frame edge sampled at E0; returns just after E1 (first grant cycle).
    task automatic frame_pulse();
        update_frame = 1'b1;
        step(1);
        update_frame = 1'b0;
        step(1);
    endtask

    initial begin
        logic [3:0] drop_seen;

        // Reset with red held: no press after release.
        reset = 1'b1;
        update_frame = 1'b0;
        enable = 1'b1;
        set_btns(4'b0010);
        step(3);
        check("reset_outputs", {mv1, gv1, gid1, drop1, pa1}, 32'h0);
        reset = 1'b0;
        drop_seen = '0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            drop_seen = drop_seen | drop1;
        end
        check("held_no_drop", drop_seen, 4'b0000);
        check("held_no_pending", pa1, 1'b0);
        frame_pulse();
        check("held_no_move", gv1, 1'b0);
        set_btns(4'b0000);

        // Single green press, single grant.
        do_reset();
        press(4'b0001);
        check("green_pending_any", pa1, 1'b1);
        frame_pulse();
        check("green_move", mv1, 4'b0001);
        check("green_valid", gv1, 1'b1);
        check("green_id", gid1, 2'd0);
        step(1);
        check("green_move_end", mv1, 4'b0000);
        check("green_valid_end", gv1, 1'b0);
        check("green_pending_clear", pa1, 1'b0);

        // All four at once, one grant per frame, round robin.
        do_reset();
        press(4'b1111);
        for (int k = 0; k < 4; k++) begin
            frame_pulse();
            check("rr_id", gid1, 32'(k));
            check("rr_move", mv1, 32'(1 << k));
            step(1);
            check("rr_gap", gv1, 1'b0);
        end

        // Saturation and drop.
        do_reset();
        press(4'b0001);
        press(4'b0001);
        press(4'b0001);
        set_btns(4'b0001);
        step(1);
        check("sat_drop", drop1, 4'b0001);
        set_btns(4'b0000);
        step(1);
        check("sat_drop_end", drop1, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            frame_pulse();
            check("sat_grant", mv1, 4'b0001);
            step(1);
        end
        frame_pulse();
        check("sat_exhausted", gv1, 1'b0);

        // Burst of 4: red then yellow back to back, mid-burst edge ignored.
        do_reset();
        press(4'b1010);
        update_frame = 1'b1;
        step(1);
        update_frame = 1'b0;
        step(1);
        check("burst_red", {mv4, gid4}, {4'b0010, 2'd1});
        update_frame = 1'b1;
        step(1);
        check("burst_yellow", {mv4, gid4}, {4'b1000, 2'd3});
        update_frame = 1'b0;
        step(1);
        check("burst_end", gv4, 1'b0);
        step(1);
        check("burst_idle", gv4, 1'b0);

        // Burst limited to 4 grants with wrap; ignored edge leaves one queued.
        do_reset();
        press(4'b0001);
        press(4'b0001);
        press(4'b0001);
        press(4'b1010);
        update_frame = 1'b1;
        step(1);
        update_frame = 1'b0;
        step(1);
        check("cap_g1", mv4, 4'b0001);
        update_frame = 1'b1;
        step(1);
        check("cap_r", mv4, 4'b0010);
        update_frame = 1'b0;
        step(1);
        check("cap_y", mv4, 4'b1000);
        step(1);
        check("cap_g2", mv4, 4'b0001);
        step(1);
        check("cap_stop", gv4, 1'b0);
        step(1);
        check("cap_edge_ignored", gv4, 1'b0);
        check("cap_left_pending", pa4, 1'b1);
        frame_pulse();
        check("cap_g3", {mv4, gid4}, {4'b0001, 2'd0});
        step(1);
        check("cap_g3_end", gv4, 1'b0);

        // Enable drop flushes pending.
        do_reset();
        press(4'b0001);
        press(4'b0001);
        enable = 1'b0;
        step(1);
        enable = 1'b1;
        step(2);
        check("flush_pending_any", pa1, 1'b0);
        frame_pulse();
        check("flush_no_grant", gv1, 1'b0);
        step(1);
        check("flush_no_grant2", gv1, 1'b0);

        // Press coincident with own grant while saturated.
        do_reset();
        press(4'b0001);
        press(4'b0001);
        press(4'b0001);
        update_frame = 1'b1;
        step(1);
        update_frame = 1'b0;
        set_btns(4'b0001);
        step(1);
        check("coinc_grant", mv1, 4'b0001);
        check("coinc_no_drop", drop1, 4'b0000);
        set_btns(4'b0000);
        step(1);
        check("coinc_no_drop2", drop1, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            frame_pulse();
            check("coinc_held", mv1, 4'b0001);
            step(1);
        end
        frame_pulse();
        check("coinc_exhausted", gv1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
